// File: rtl/xcr_int_seq.sv
// xcr_int_seq: interrupt entry/return sequencer with a small control-register file.
// Saves the interrupted PC in EPC, redirects fetch to the handler, and redirects
// back to EPC when the handler retires its return instruction.
// Optional build macro XCR_INT_LATCNT_EN adds an interrupt-latency counter whose
// worst case is kept in LATMAX (0x4). Without it, 0x4 reads 0x00.
//
// state  | meaning
// IDLE   | no handler active; waits for INT at an instruction boundary
// ENTER  | redirect to IVEC_ADDR requested, waiting for fetch ack
// ISR    | handler running; further INT ignored until RETI
// RETURN | redirect to EPC requested, waiting for fetch ack
module xcr_int_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        INT,
  input  logic [23:0] IVEC_ADDR,
  input  logic [23:0] PC_CUR,
  input  logic        INSN_BND,
  input  logic        RETI,
  output logic        JMP_REQ,
  output logic [23:0] JMP_ADDR,
  input  logic        JMP_ACK,
  output logic        IN_ISR,
  input  logic [7:0]  cr_din,
  output logic [7:0]  cr_dout,
  input  logic [2:0]  cr_adr,
  input  logic        cr_we,
  input  logic        cr_cs
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ENTER  = 2'd1,
    S_ISR    = 2'd2,
    S_RETURN = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        jmp_req_q, jmp_req_d;
  logic        in_isr_q, in_isr_d;
  logic [23:0] epc_q, epc_d;
  logic [7:0]  entcnt_q, entcnt_d;
  logic        cr_wr;
  logic        take_int;
  logic        enter_ack;
  logic [7:0]  latmax_rd;

  assign cr_wr     = cr_cs & cr_we;
  assign take_int  = (state_q == S_IDLE) & INT & INSN_BND;
  assign enter_ack = (state_q == S_ENTER) & JMP_ACK;

  // Next-state logic; request and IN_ISR are derived from the next state so they register with it
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (take_int) state_d = S_ENTER;
      S_ENTER:  if (JMP_ACK)  state_d = S_ISR;
      S_ISR:    if (RETI)     state_d = S_RETURN;
      S_RETURN: if (JMP_ACK)  state_d = S_IDLE;
      default:                state_d = S_IDLE;
    endcase
    jmp_req_d = (state_d == S_ENTER) || (state_d == S_RETURN);
    in_isr_d  = (state_d != S_IDLE);
  end

  // EPC capture beats a same-cycle software write; ENTCNT clear beats a same-cycle increment
  always_comb begin
    epc_d    = epc_q;
    entcnt_d = entcnt_q;
    if (take_int) begin
      epc_d = PC_CUR;
    end else if (cr_wr) begin
      case (cr_adr)
        3'h1:    epc_d[7:0]   = cr_din;
        3'h2:    epc_d[15:8]  = cr_din;
        3'h3:    epc_d[23:16] = cr_din;
        default: epc_d        = epc_q;
      endcase
    end
    if (cr_wr && (cr_adr == 3'h5)) begin
      entcnt_d = 8'h00;
    end else if (enter_ack) begin
      entcnt_d = entcnt_q + 8'h01;
    end
  end

  // Sequencer and register-file state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      jmp_req_q <= 1'b0;
      in_isr_q  <= 1'b0;
      epc_q     <= 24'h0;
      entcnt_q  <= 8'h00;
    end else begin
      state_q   <= state_d;
      jmp_req_q <= jmp_req_d;
      in_isr_q  <= in_isr_d;
      epc_q     <= epc_d;
      entcnt_q  <= entcnt_d;
    end
  end

`ifdef XCR_INT_LATCNT_EN
  logic [7:0] lat_cnt_q, lat_cnt_d;
  logic [7:0] latmax_q, latmax_d;

  // Latency counter saturates at 0xFF; worst case folded into LATMAX on entry ack
  always_comb begin
    lat_cnt_d = lat_cnt_q;
    latmax_d  = latmax_q;
    if (enter_ack) begin
      lat_cnt_d = 8'h00;
      if (lat_cnt_q > latmax_q) latmax_d = lat_cnt_q;
    end else if (INT && ((state_q == S_IDLE) || (state_q == S_ENTER)) && (lat_cnt_q != 8'hFF)) begin
      lat_cnt_d = lat_cnt_q + 8'h01;
    end
    if (cr_wr && (cr_adr == 3'h4)) latmax_d = 8'h00;
  end

  // Latency counter and LATMAX registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_cnt_q <= 8'h00;
      latmax_q  <= 8'h00;
    end else begin
      lat_cnt_q <= lat_cnt_d;
      latmax_q  <= latmax_d;
    end
  end

  assign latmax_rd = latmax_q;
`else
  assign latmax_rd = 8'h00;
`endif

  assign JMP_REQ  = jmp_req_q;
  assign IN_ISR   = in_isr_q;
  assign JMP_ADDR = (state_q == S_RETURN) ? epc_q : IVEC_ADDR;

  // Combinational register read mux
  always_comb begin
    cr_dout = 8'h00;
    case (cr_adr)
      3'h0:    cr_dout = {in_isr_q, state_q, 5'b0};
      3'h1:    cr_dout = epc_q[7:0];
      3'h2:    cr_dout = epc_q[15:8];
      3'h3:    cr_dout = epc_q[23:16];
      3'h4:    cr_dout = latmax_rd;
      3'h5:    cr_dout = entcnt_q;
      default: cr_dout = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_xcr_int_seq.sv
// Directed bench for xcr_int_seq; expected values are queued when stimulus is
// driven and compared after the DUT has had its clock edge.
module tb_xcr_int_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic        INT;
  logic [23:0] IVEC_ADDR;
  logic [23:0] PC_CUR;
  logic        INSN_BND;
  logic        RETI;
  logic        JMP_REQ;
  logic [23:0] JMP_ADDR;
  logic        JMP_ACK;
  logic        IN_ISR;
  logic [7:0]  cr_din;
  logic [7:0]  cr_dout;
  logic [2:0]  cr_adr;
  logic        cr_we;
  logic        cr_cs;

  int n_pass  = 0;
  int n_total = 0;
  logic [23:0] sb_q[$];

  xcr_int_seq dut (
    .clk(clk), .rst(rst), .INT(INT), .IVEC_ADDR(IVEC_ADDR), .PC_CUR(PC_CUR),
    .INSN_BND(INSN_BND), .RETI(RETI), .JMP_REQ(JMP_REQ), .JMP_ADDR(JMP_ADDR),
    .JMP_ACK(JMP_ACK), .IN_ISR(IN_ISR), .cr_din(cr_din), .cr_dout(cr_dout),
    .cr_adr(cr_adr), .cr_we(cr_we), .cr_cs(cr_cs)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input logic [23:0] e);
    sb_q.push_back(e);
  endtask

  task automatic chk(input string tag, input logic [23:0] obs);
    logic [23:0] e;
    n_total++;
    if (sb_q.size() == 0) begin
      $error("FAIL %s scoreboard empty, observed=%h", tag, obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
  endtask

  task automatic rd(input logic [2:0] a, output logic [7:0] d);
    cr_adr = a;
    #1;
    d = cr_dout;
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] a, input logic [7:0] e);
    logic [7:0] d;
    push({16'h0, e});
    rd(a, d);
    chk(tag, {16'h0, d});
  endtask

  task automatic cr_write(input logic [2:0] a, input logic [7:0] d);
    cr_cs = 1'b1; cr_we = 1'b1; cr_adr = a; cr_din = d;
    tick();
    cr_cs = 1'b0; cr_we = 1'b0;
  endtask

  task automatic do_entry(input logic [23:0] pc);
    INT = 1'b1; PC_CUR = pc; INSN_BND = 1'b1;
    tick();
    INT = 1'b0; INSN_BND = 1'b0; JMP_ACK = 1'b1;
    tick();
    JMP_ACK = 1'b0;
  endtask

  task automatic do_return();
    RETI = 1'b1;
    tick();
    RETI = 1'b0; JMP_ACK = 1'b1;
    tick();
    JMP_ACK = 1'b0;
  endtask

  initial begin
    rst = 1'b0; INT = 1'b0; IVEC_ADDR = 24'h001200; PC_CUR = 24'h0; INSN_BND = 1'b0;
    RETI = 1'b0; JMP_ACK = 1'b0; cr_din = 8'h0; cr_adr = 3'h0; cr_we = 1'b0; cr_cs = 1'b0;
    #2;
    push(24'h0);      chk("rst_jmp_req", {23'h0, JMP_REQ});
    push(24'h0);      chk("rst_in_isr", {23'h0, IN_ISR});
    push(24'h001200); chk("rst_jmp_addr", JMP_ADDR);
    rd_chk("rst_stat", 3'h0, 8'h00);
    tick();
    rst = 1'b1;
    tick();

    // first entry
    INT = 1'b1; PC_CUR = 24'h000345; INSN_BND = 1'b1;
    push(24'h1); push(24'h001200);
    tick();
    INSN_BND = 1'b0; INT = 1'b0;
    chk("enter_req", {23'h0, JMP_REQ});
    chk("enter_addr", JMP_ADDR);
    rd_chk("epc0", 3'h1, 8'h45);
    rd_chk("epc1", 3'h2, 8'h03);
    rd_chk("epc2", 3'h3, 8'h00);
    rd_chk("stat_enter", 3'h0, 8'hA0);
    tick();
    push(24'h1); chk("enter_hold_no_cancel", {23'h0, JMP_REQ});
    JMP_ACK = 1'b1;
    tick();
    JMP_ACK = 1'b0;
    push(24'h1); chk("isr_in_isr", {23'h0, IN_ISR});
    push(24'h0); chk("isr_req_low", {23'h0, JMP_REQ});
    rd_chk("entcnt1", 3'h5, 8'h01);
    rd_chk("stat_isr", 3'h0, 8'hC0);

    // EPC write in ISR, then return
    cr_write(3'h1, 8'h80);
    rd_chk("epc_wr", 3'h1, 8'h80);
    RETI = 1'b1;
    tick();
    RETI = 1'b0;
    push(24'h1); chk("ret_req", {23'h0, JMP_REQ});
    push(24'h000380); chk("ret_addr", JMP_ADDR);
    rd_chk("stat_ret", 3'h0, 8'hE0);
    JMP_ACK = 1'b1;
    tick();
    JMP_ACK = 1'b0;
    push(24'h0); chk("idle_in_isr", {23'h0, IN_ISR});
    rd_chk("stat_idle", 3'h0, 8'h00);

    // stray ACK / RETI in IDLE are ignored
    JMP_ACK = 1'b1; RETI = 1'b1;
    tick();
    JMP_ACK = 1'b0; RETI = 1'b0;
    rd_chk("stray_ignored", 3'h0, 8'h00);

    // no nesting; return priority over pending INT; re-entry after IDLE
    do_entry(24'h000100);
    INT = 1'b1; INSN_BND = 1'b1;
    tick();
    INSN_BND = 1'b0;
    rd_chk("no_nest_stat", 3'h0, 8'hC0);
    rd_chk("no_nest_epc", 3'h1, 8'h00);
    RETI = 1'b1;
    tick();
    RETI = 1'b0; PC_CUR = 24'h000777;
    rd_chk("reti_prio", 3'h0, 8'hE0);
    push(24'h000100); chk("ret_addr2", JMP_ADDR);
    JMP_ACK = 1'b1;
    tick();
    JMP_ACK = 1'b0;
    rd_chk("back_idle", 3'h0, 8'h00);
    INSN_BND = 1'b1;
    tick();
    INSN_BND = 1'b0;
    rd_chk("reenter_stat", 3'h0, 8'hA0);
    rd_chk("reenter_epc0", 3'h1, 8'h77);
    rd_chk("reenter_epc1", 3'h2, 8'h07);

    // long ENTER with INT held high
    for (int i = 0; i < 300; i++) tick();
    JMP_ACK = 1'b1;
    tick();
    JMP_ACK = 1'b0; INT = 1'b0;
    rd_chk("entcnt3", 3'h5, 8'h03);
`ifdef XCR_INT_LATCNT_EN
    rd_chk("latmax_sat", 3'h4, 8'hFF);
`else
    rd_chk("latmax_off", 3'h4, 8'h00);
`endif
    cr_write(3'h4, 8'h5A);
    rd_chk("latmax_clr", 3'h4, 8'h00);
    do_return();

    // EPC capture wins over same-cycle write
    INT = 1'b1; INSN_BND = 1'b1; PC_CUR = 24'h0000AA;
    cr_cs = 1'b1; cr_we = 1'b1; cr_adr = 3'h1; cr_din = 8'h55;
    tick();
    cr_cs = 1'b0; cr_we = 1'b0; INT = 1'b0; INSN_BND = 1'b0;
    rd_chk("epc_cap_wins", 3'h1, 8'hAA);
    JMP_ACK = 1'b1;
    tick();
    JMP_ACK = 1'b0;
    do_return();

    // ENTCNT clear, wrap, clear-vs-increment
    cr_write(3'h5, 8'hA5);
    rd_chk("entcnt_clr", 3'h5, 8'h00);
    for (int i = 0; i < 255; i++) begin
      do_entry(24'h000010);
      do_return();
    end
    rd_chk("entcnt_ff", 3'h5, 8'hFF);
    do_entry(24'h000020);
    do_return();
    rd_chk("entcnt_wrap", 3'h5, 8'h00);
    do_entry(24'h000030);
    do_return();
    rd_chk("entcnt_one", 3'h5, 8'h01);
    INT = 1'b1; INSN_BND = 1'b1; PC_CUR = 24'h000040;
    tick();
    INT = 1'b0; INSN_BND = 1'b0;
    JMP_ACK = 1'b1; cr_cs = 1'b1; cr_we = 1'b1; cr_adr = 3'h5; cr_din = 8'h01;
    tick();
    JMP_ACK = 1'b0; cr_cs = 1'b0; cr_we = 1'b0;
    rd_chk("entcnt_clr_wins", 3'h5, 8'h00);
    rd_chk("isr_after_clr", 3'h0, 8'hC0);
    do_return();

    // reset during RETURN
    do_entry(24'h00ABCD);
    RETI = 1'b1;
    tick();
    RETI = 1'b0;
    push(24'h1); chk("pre_rst_req", {23'h0, JMP_REQ});
    rst = 1'b0;
    #1;
    push(24'h0); chk("rst_async_req", {23'h0, JMP_REQ});
    push(24'h0); chk("rst_async_isr", {23'h0, IN_ISR});
    tick();
    rst = 1'b1;
    tick();
    rd_chk("post_rst_stat", 3'h0, 8'h00);
    rd_chk("post_rst_epc0", 3'h1, 8'h00);
    rd_chk("post_rst_epc1", 3'h2, 8'h00);
    rd_chk("post_rst_epc2", 3'h3, 8'h00);
    rd_chk("post_rst_entcnt", 3'h5, 8'h00);
    cr_write(3'h6, 8'hFF);
    rd_chk("adr6", 3'h6, 8'h00);
    rd_chk("adr7", 3'h7, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
